// File: rtl/display_scan_if.sv
// Front-panel display bus: formatted digit data in, multiplexed DIG/SEG pin drive out.
interface display_scan_if #(
  parameter int DIGITS   = 8,
  parameter int PWM_BITS = 4
);
  logic                  enable;
  logic [8*DIGITS-1:0]   seg_in;
  logic [DIGITS-1:0]     blink_mask;
  logic [PWM_BITS-1:0]   brightness;
  logic [DIGITS-1:0]     dig;
  logic [7:0]            seg;
  logic                  frame_tick;

  modport master (
    output enable, seg_in, blink_mask, brightness,
    input  dig, seg, frame_tick
  );

  modport slave (
    input  enable, seg_in, blink_mask, brightness,
    output dig, seg, frame_tick
  );
endinterface

// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner with per-digit blink, PWM brightness and a
// blank interval at the start of every digit slot; all pins are registered.
module display_scan #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int DIGITS         = 8,
  parameter int REFRESH_HZ     = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int PWM_BITS       = 4,
  parameter int BLINK_HZ       = 2,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic           clk_sys,
  input  logic           reset,
  display_scan_if.slave  bus
);
  localparam int DIV   = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int ON    = DIV - BLANK_CYCLES;
  localparam int SLICE = ON >> PWM_BITS;
  localparam int BHALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW    = $clog2(DIV + 1);
  localparam int IW    = $clog2(DIGITS);
  localparam int BW    = $clog2(BHALF + 1);
  localparam int TW    = SW + PWM_BITS;

  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW != 0}};
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};

  if (DIV < BLANK_CYCLES + (1 << PWM_BITS)) begin : g_bad_cfg
    $error("display_scan: slot too short for blank interval plus PWM steps");
  end

  typedef enum logic {S_BLANK, S_ON} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [7:0]            lseg_q, lseg_d;
  logic                  lblink_q, lblink_d;
  logic [PWM_BITS-1:0]   lbri_q, lbri_d;
  logic                  lphase_q, lphase_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic                  ft_q, ft_d;
  logic [TW-1:0]         off;
  logic [TW-1:0]         thr;
  logic                  lit;

  always_comb begin
    slot_d   = slot_q + 1'b1;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q + 1'b1;
    phase_d  = phase_q;
    lseg_d   = lseg_q;
    lblink_d = lblink_q;
    lbri_d   = lbri_q;
    lphase_d = lphase_q;

    if (slot_q == SW'(DIV - 1)) begin
      slot_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    if (bcnt_q == BW'(BHALF - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end

    state_d = (slot_d < SW'(BLANK_CYCLES)) ? S_BLANK : S_ON;

    // Blink phase is captured with the data so a toggle darkens whole slots only.
    if (slot_q == '0) begin
      lseg_d   = bus.seg_in[8*idx_q +: 8];
      lblink_d = bus.blink_mask[idx_q];
      lbri_d   = bus.brightness;
      lphase_d = phase_q;
    end

    off = TW'(slot_q) - TW'(BLANK_CYCLES);
    thr = TW'(lbri_q) * TW'(SLICE);
    lit = bus.enable && (state_q == S_ON) && (off < thr) && !(lblink_q && lphase_q);

    dig_d = (lit ? (DIGITS'(1) << idx_q) : '0) ^ DIG_OFF;
    seg_d = (lit ? lseg_q : '0) ^ SEG_OFF;
    ft_d  = (slot_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_BLANK;
      slot_q   <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      lseg_q   <= '0;
      lblink_q <= 1'b0;
      lbri_q   <= '0;
      lphase_q <= 1'b0;
      dig_q    <= DIG_OFF;
      seg_q    <= SEG_OFF;
      ft_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      lseg_q   <= lseg_d;
      lblink_q <= lblink_d;
      lbri_q   <= lbri_d;
      lphase_q <= lphase_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      ft_q     <= ft_d;
    end
  end

  assign bus.dig        = dig_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = ft_q;
endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Parametrised multiplexed 7-segment display driver; the next generation of the board display path.
- Scans DIGITS digits from per-digit raw segment data and adds per-digit blink, PWM brightness and an anti-ghosting blank interval.
- Segment and digit pin polarity are configurable.
- Sits in the platform top between the front-panel formatting logic and the board DIG/SEG pins, clocked from the board clock.

Parameters:
- CLK_HZ, 50_000_000, clk_sys frequency in Hz.
- DIGITS, 8, number of multiplexed digits (2..16).
- REFRESH_HZ, 1000, full-frame refresh rate in Hz.
- BLANK_CYCLES, 16, dead-time cycles at the start of every digit slot with all outputs inactive.
- PWM_BITS, 4, brightness resolution in bits.
- BLINK_HZ, 2, blink rate in Hz (one on phase plus one off phase per period).
- DIG_ACTIVE_LOW, 1, 1 = digit enables active-low.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low.

Ports:
- clk_sys  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  0 forces all outputs inactive; counters keep running.
- seg_in  input  8*DIGITS  raw segments, digit k = seg_in[8k+7:8k], bit 7 = DP; 1 = lit.
- blink_mask  input  DIGITS  1 = digit blinks.
- brightness  input  PWM_BITS  0 = dark, 2^PWM_BITS-1 = maximum.
- dig  output  DIGITS  digit enables, polarity per DIG_ACTIVE_LOW.
- seg  output  8  segment drive, polarity per SEG_ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Derived constants:
  - DIV = CLK_HZ/(REFRESH_HZ*DIGITS) cycles per digit slot.
  - ON = DIV-BLANK_CYCLES.
  - SLICE = ON>>PWM_BITS.
  - BHALF = CLK_HZ/(2*BLINK_HZ).
  - Elaboration fails if DIV < BLANK_CYCLES + 2^PWM_BITS.
- Slot counter 0..DIV-1 and digit index 0..DIGITS-1, both incrementing. The digit index advances and wraps to 0 when the slot counter wraps.
- Slot FSM:
  - BLANK (slot count < BLANK_CYCLES): all digits and segments inactive.
  - ON (remaining cycles): current digit driven.
  - No other states. Transitions depend only on the slot counter.
- Data latch: the current digit's seg_in byte, its blink_mask bit and brightness are captured in the first BLANK cycle of each slot. Input changes mid-slot are not visible until that digit's next slot.
- PWM: ON-cycle offset o = slot-BLANK_CYCLES. The digit is lit iff o < latched_brightness*SLICE. The remainder ON-(2^PWM_BITS-1)*SLICE cycles at the end of the slot are always dark.
- Blink: a free-running counter toggles blink_phase every BHALF cycles. While blink_phase=1, a digit with its latched blink bit set is dark for the whole slot.
- Lit digit: dig has only the current index bit active; seg = latched byte; polarity inversion applied last.
- Dark (any cause, including enable=0): all dig bits inactive and seg = all-inactive.
- Outputs are registered: pins reflect the internal state one cycle later.
- frame_tick is high for the one cycle in which the registered outputs begin slot 0 BLANK.
- Reset:
  - slot, digit index, blink counter and blink_phase = 0; FSM in BLANK.
  - Latched data cleared.
  - dig and seg inactive (all ones when active-low); frame_tick = 0.
  - Reset asserted mid-slot takes effect on the next edge.
  - The first cycle after release begins slot 0 BLANK with frame_tick=1.
- Simultaneous events: a blink toggle coincident with a slot boundary applies to the new slot. A brightness change during a slot has no effect until the next latch.

Test Plan:
- Bench parameters: CLK_HZ=64000, REFRESH_HZ=250, DIGITS=4, BLANK_CYCLES=16, PWM_BITS=4, BLINK_HZ=125. This gives DIV=64, SLICE=3, BHALF=256.
- Reset and first slot:
  - Stimulus: seg_in=32'h0000_00A5, brightness=15, enable=1, release reset.
  - Response: frame_tick=1 in cycle 1, then dig=4'hF, seg=8'hFF for 16 cycles, then dig=4'hE, seg=8'h5A for 45 cycles, then dark for 3.
- Brightness:
  - brightness=1 -> digit lit exactly 3 cycles per slot.
  - brightness=0 -> dig never leaves 4'hF.
  - brightness=8 -> lit 24 cycles.
- Scan order and frame:
  - Stimulus: all bytes 8'hFF.
  - Response: active dig sequence E,D,B,7 repeats; frame_tick pulses every 256 cycles, aligned with slot 0 BLANK start.
- Blink:
  - Stimulus: blink_mask=4'b0100.
  - Response: digit 2 lit in frames 0,2,4 and dark in frames 1,3,5; digits 0,1,3 lit every frame.
- Latch integrity:
  - Stimulus: change seg_in[7:0] from 8'h11 to 8'h22 at slot-0 offset 30.
  - Response: seg stays 8'hEE to slot end; shows 8'hDD from the next frame.
- Enable and mid-scan reset:
  - enable=0 for 100 cycles -> outputs inactive; frame_tick period stays 256.
  - reset pulse at slot-2 offset 40 -> next cycle begins slot 0 BLANK with outputs inactive.
